// File: rtl/vga_timing_pkg.sv
// Shared 1024x768@60 raster timing constants for the visualiser video path.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 1024;
    localparam int H_FP         = 24;
    localparam int H_SYNC       = 136;
    localparam int H_BP         = 160;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE     = 768;
    localparam int V_FP         = 3;
    localparam int V_SYNC       = 6;
    localparam int V_BP         = 29;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    // Idle levels of {hsync, vsync, blank} held in the delay line after reset.
    localparam logic [2:0] SYNC_RESET_VAL = 3'b111;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-latency shift register that lines the syncs up with the pixel pipeline.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clk ^ reset_n;
            assign dout      = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            // Shift the input one stage per clock; every stage resets to the idle value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= RESET_VAL;
                    end
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xvga_timing_gen.sv
// Raster timing source: pixel/line counters, registered sync/blank decode,
// pipeline-aligned sync copies, and a synchronous frame strobe and counter.
module xvga_timing_gen #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = 3
) (
    input  logic                                clk,
    input  logic                                reset_n,
    output logic [vga_timing_pkg::HCOUNT_W-1:0] hcount,
    output logic [vga_timing_pkg::VCOUNT_W-1:0] vcount,
    output logic                                hsync,
    output logic                                vsync,
    output logic                                blank,
    output logic                                hsync_d,
    output logic                                vsync_d,
    output logic                                blank_d,
    output logic                                frame_start,
    output logic [15:0]                         frame_count
);

    import vga_timing_pkg::*;

    localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(LINE_LEN - 1);
    localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(H_ACTIVE);
    localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(FRAME_LINES - 1);
    localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(V_ACTIVE);
    localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCOUNT_W-1:0] h_next;
    logic [VCOUNT_W-1:0] v_next;
    logic                h_wrap;
    logic                v_wrap;
    logic [2:0]          delayed;

    // Next raster position; decode works from this so syncs land with their counters.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_next = h_wrap ? '0 : hcount + HCOUNT_W'(1);
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + VCOUNT_W'(1);
        end
    end

    // Counters, sync/blank decode and frame strobe all registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            blank       <= (h_next >= H_ACT) || (v_next >= V_ACT);
            hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
            frame_start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_RESET_VAL)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({hsync, vsync, blank}),
        .dout    (delayed)
    );

    assign {hsync_d, vsync_d, blank_d} = delayed;

endmodule
